// File: rtl/seg7_decoder.sv
// Seven-segment pattern decoder with debounce, glyph decode and error count.
// Optional sequence checker enabled by defining SEG7_SEQ_CHECK_EN.
module seg7_decoder #(
    parameter int STABLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       err_clr,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       invalid,
    output logic       seq_err,
    output logic [7:0] err_cnt
);

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    logic [6:0] s1;
    logic [3:0] run;
    logic       taken;
    logic       accept;
    logic [3:0] value;
    logic       is_glyph;
    logic       is_blank;
    logic       seq_bad;
    logic       bump;

    // taken blocks a second accept when run sits saturated at 15
    assign accept = (run == STABLE) && !taken;

    // sample register and stability run counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= '0;
            run   <= '0;
            taken <= 1'b0;
        end else if (seg_in != s1) begin
            s1    <= seg_in;
            run   <= 4'd1;
            taken <= 1'b0;
        end else begin
            if (run != 4'd15) begin
                run <= run + 4'd1;
            end
            if (accept) begin
                taken <= 1'b1;
            end
        end
    end

    // glyph lookup of the sampled pattern
    always_comb begin
        value    = 4'd0;
        is_glyph = 1'b1;
        case (s1)
            7'h3F:   value = 4'd0;
            7'h06:   value = 4'd1;
            7'h5B:   value = 4'd2;
            7'h4F:   value = 4'd3;
            7'h66:   value = 4'd4;
            7'h6D:   value = 4'd5;
            7'h7D:   value = 4'd6;
            7'h07:   value = 4'd7;
            7'h7F:   value = 4'd8;
            7'h67:   value = 4'd9;
            default: is_glyph = 1'b0;
        endcase
    end

    assign is_blank = (s1 == 7'h00);

`ifdef SEG7_SEQ_CHECK_EN
    typedef enum logic {
        IDLE,
        TRACK
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] last;
    logic [3:0] succ;

    assign succ = (last == 4'd9) ? 4'd0 : last + 4'd1;

    // state register and reference digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= '0;
        end else begin
            state <= state_next;
            if (accept && is_glyph) begin
                last <= value;
            end
        end
    end

    // next state and sequence violation detect
    always_comb begin
        state_next = state;
        seq_bad    = 1'b0;
        if (accept) begin
            if (is_glyph) begin
                state_next = TRACK;
                seq_bad    = (state == TRACK) && (value != succ);
            end else begin
                state_next = IDLE;
            end
        end
    end
`else
    assign seq_bad = 1'b0;
`endif

    assign bump = accept && ((!is_glyph && !is_blank) || seq_bad);

    // registered outputs updated on accept events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit       <= '0;
            digit_valid <= 1'b0;
            invalid     <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            digit_valid <= 1'b0;
            seq_err     <= seq_bad;
            if (accept) begin
                if (is_glyph) begin
                    digit       <= value;
                    digit_valid <= 1'b1;
                    invalid     <= 1'b0;
                end else if (is_blank) begin
                    invalid <= 1'b0;
                end else begin
                    invalid <= 1'b1;
                end
            end
        end
    end

    // saturating error counter, clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (bump && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_seg7_decoder.sv
// Scoreboard bench for seg7_decoder, two instances (STABLE_CYCLES 1 and 3).
// Reference model tracks unbounded hold lengths and decodes via table search.
module tb_seg7_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_in = '0;
    logic       err_clr = 1'b0;

    logic [3:0] d1, d3;
    logic       dv1, dv3, inv1, inv3, se1, se3;
    logic [7:0] ec1, ec3;

    always #5 clk = ~clk;

    seg7_decoder #(.STABLE_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .seg_in(seg_in), .err_clr(err_clr),
        .digit(d1), .digit_valid(dv1), .invalid(inv1),
        .seq_err(se1), .err_cnt(ec1)
    );

    seg7_decoder #(.STABLE_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .seg_in(seg_in), .err_clr(err_clr),
        .digit(d3), .digit_valid(dv3), .invalid(inv3),
        .seq_err(se3), .err_cnt(ec3)
    );

    typedef struct packed {
        logic [3:0] digit;
        logic       dv;
        logic       inv;
        logic       se;
        logic [7:0] cnt;
    } exp_t;

    typedef struct packed {
        exp_t e1;
        exp_t e3;
    } pair_t;

    pair_t q[$];

    int n_chk = 0;
    int n_fail = 0;

    int glyph[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66,
                      'h6D, 'h7D, 'h07, 'h7F, 'h67};
    int s_of[2] = '{1, 3};

    logic [6:0] m_pat[2];
    int         m_len[2];
    bit         m_track[2];
    int         m_last[2];
    int         m_digit[2];
    bit         m_inv[2];
    int         m_cnt[2];

    function automatic int lookup(logic [6:0] p);
        for (int i = 0; i < 10; i++) begin
            if (int'(p) == glyph[i]) return i;
        end
        return -1;
    endfunction

    // advance model instance k by one clock edge
    function automatic exp_t model_edge(int k);
        exp_t e;
        bit   acc;
        bit   bump;
        int   v;
        e    = '0;
        bump = 1'b0;
        if (rst) begin
            m_pat[k]   = '0;
            m_len[k]   = 0;
            m_track[k] = 1'b0;
            m_last[k]  = 0;
            m_digit[k] = 0;
            m_inv[k]   = 1'b0;
            m_cnt[k]   = 0;
            return e;
        end
        acc = (m_len[k] == s_of[k]);
        v   = lookup(m_pat[k]);
        if (acc) begin
            if (v >= 0) begin
`ifdef SEG7_SEQ_CHECK_EN
                if (m_track[k] && v != (m_last[k] + 1) % 10) begin
                    e.se = 1'b1;
                    bump = 1'b1;
                end
                m_track[k] = 1'b1;
                m_last[k]  = v;
`endif
                m_digit[k] = v;
                e.dv       = 1'b1;
                m_inv[k]   = 1'b0;
            end else if (m_pat[k] == 7'h00) begin
                m_inv[k]   = 1'b0;
                m_track[k] = 1'b0;
            end else begin
                m_inv[k]   = 1'b1;
                m_track[k] = 1'b0;
                bump       = 1'b1;
            end
        end
        if (err_clr) m_cnt[k] = 0;
        else if (bump && m_cnt[k] < 255) m_cnt[k]++;
        if (seg_in != m_pat[k]) begin
            m_pat[k] = seg_in;
            m_len[k] = 1;
        end else begin
            m_len[k]++;
        end
        e.digit = 4'(m_digit[k]);
        e.inv   = m_inv[k];
        e.cnt   = 8'(m_cnt[k]);
        return e;
    endfunction

    task automatic step(input logic [6:0] p, input bit clr = 1'b0,
                        input bit r = 1'b0);
        pair_t pr;
        @(negedge clk);
        seg_in  = p;
        err_clr = clr;
        rst     = r;
        pr.e1   = model_edge(0);
        pr.e3   = model_edge(1);
        q.push_back(pr);
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        for (int i = 0; i < n; i++) step(p);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0d required=%0d",
                     name, $time, act, req);
        end
    endtask

    // monitor: pop one expectation per edge and compare both instances
    initial begin
        pair_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("s1_digit", int'(d1), int'(x.e1.digit));
                chk("s1_valid", int'(dv1), int'(x.e1.dv));
                chk("s1_invalid", int'(inv1), int'(x.e1.inv));
                chk("s1_seq_err", int'(se1), int'(x.e1.se));
                chk("s1_err_cnt", int'(ec1), int'(x.e1.cnt));
                chk("s3_digit", int'(d3), int'(x.e3.digit));
                chk("s3_valid", int'(dv3), int'(x.e3.dv));
                chk("s3_invalid", int'(inv3), int'(x.e3.inv));
                chk("s3_seq_err", int'(se3), int'(x.e3.se));
                chk("s3_err_cnt", int'(ec3), int'(x.e3.cnt));
            end
        end
    end

    initial begin
        int idx;
        int sel;
        int n;
        logic [6:0] p;

        step(7'h00, 1'b0, 1'b1);
        step(7'h00, 1'b0, 1'b1);
        hold(7'h00, 4);

        // glyphs 0..9,0 stepped every cycle, then held
        for (int i = 0; i <= 10; i++) step(7'(glyph[i % 10]));
        hold(7'h3F, 4);

        // 1,2,4 out of order
        hold(7'h00, 4);
        step(7'h06);
        step(7'h5B);
        hold(7'h66, 5);

        // toggling below the stability window, then a held 3
        hold(7'h00, 4);
        for (int i = 0; i < 4; i++) begin
            hold(7'h3F, 2);
            hold(7'h06, 2);
        end
        hold(7'h4F, 6);

        // invalid, blank, glyph
        hold(7'h12, 4);
        hold(7'h00, 4);
        hold(7'h06, 4);

        // saturate the counter then clear alongside another increment
        for (int i = 0; i < 260; i++) step((i % 2) ? 7'h13 : 7'h12);
        step(7'h12, 1'b1);
        hold(7'h00, 3);

        // reset mid-stream at digit 5
        hold(7'h66, 4);
        hold(7'h6D, 4);
        step(7'h6D, 1'b0, 1'b1);
        hold(7'h6D, 5);

        // randomized patterns with random hold lengths
        idx = 0;
        for (int i = 0; i < 120; i++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0: idx = $urandom_range(0, 9);
                1, 2: idx = (idx + 1) % 10;
                default: ;
            endcase
            if (sel <= 2) p = 7'(glyph[idx]);
            else if (sel == 3) p = 7'h00;
            else p = 7'($urandom_range(0, 127));
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) begin
                step(p, ($urandom_range(0, 15) == 0));
            end
        end

        hold(7'h00, 2);
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_decoder.md
SEG7_DECODER -- requirements
Module: seg7_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 1, meaning the number of consecutive clk edges a pattern must hold before acceptance (range 1-15).
REQ-002 The block SHALL have the port clk, input, 1 bit: clock; all logic SHALL be on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have the port seg_in, input, 7 bits: segment pattern, bit0=a through bit6=g, active-high.
REQ-005 The block SHALL have the port err_clr, input, 1 bit: synchronous clear of err_cnt.
REQ-006 The block SHALL have the port digit, output, 4 bits: the last accepted decimal value.
REQ-007 The block SHALL have the port digit_valid, output, 1 bit: a one-cycle pulse marking a newly accepted digit.
REQ-008 The block SHALL have the port invalid, output, 1 bit: level, high when the last accepted non-blank pattern was not a glyph.
REQ-009 The block SHALL have the port seq_err, output, 1 bit: a one-cycle pulse on an out-of-sequence digit.
REQ-010 The block SHALL have the port err_cnt, output, 8 bits: a saturating error count.

Function
REQ-011 The glyph table SHALL be 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x67; 0x00 is "blank"; every other value is invalid.
REQ-012 Sampling: on each edge, if seg_in differs from the sample register s1, then s1<=seg_in and run<=1; otherwise run<=run+1, saturating at 15.
REQ-013 An accept event SHALL occur on the edge where run==STABLE_CYCLES; it occurs exactly once per unchanged run, and a held pattern is never re-accepted.
REQ-014 Latency: for a pattern first present at edge N and held, the outputs SHALL update at edge N+STABLE_CYCLES.
REQ-015 The FSM SHALL have the states IDLE (no reference digit) and TRACK (reference digit held in last).
REQ-016 Valid glyph accepted: digit<=value, digit_valid=1 for one cycle, invalid<=0, last<=value, state<=TRACK.
REQ-017 Sequence check: if the state is TRACK and value != (last+1) mod 10, then seq_err=1 for one cycle and err_cnt increments; 9 followed by 0 SHALL be legal.
REQ-018 Invalid non-blank accepted: invalid<=1, held until the next accepted glyph or blank; digit holds; digit_valid=0; err_cnt increments; state<=IDLE.
REQ-019 Blank accepted: invalid<=0, state<=IDLE, digit holds, no pulse, no count.
REQ-020 err_cnt SHALL saturate at 255; when err_clr and an increment occur in the same cycle, the clear wins and the result is 0.
REQ-021 An accept event SHALL never raise both seq_err and invalid.
REQ-022 From IDLE, the first valid glyph SHALL never raise seq_err.

Reset
REQ-023 While rst is high, s1, run, digit, digit_valid, invalid, seq_err and err_cnt SHALL all be 0, and the state SHALL be IDLE.
REQ-024 rst asserted mid-run SHALL discard the partial run; after release, a held pattern SHALL need a full STABLE_CYCLES run before acceptance.

Configuration
REQ-025 Macro SEG7_SEQ_CHECK_EN defined: the sequence checker SHALL be present as in REQ-017 and REQ-022.
REQ-026 Macro SEG7_SEQ_CHECK_EN undefined: the sequence logic, last register and FSM SHALL be absent; seq_err SHALL be tied to 0; err_cnt SHALL count only invalid patterns.

Verification
REQ-027 STABLE_CYCLES=1, seg_in stepped 0x3F,0x06,...,0x67,0x3F each cycle -> digit_valid every cycle, digit 0..9,0, seq_err never set, err_cnt=0.
REQ-028 STABLE_CYCLES=1, sequence 0x06,0x5B,0x66 -> seq_err pulse with digit=4, err_cnt=1.
REQ-029 STABLE_CYCLES=3, seg_in toggles 0x3F/0x06 every 2 cycles then holds 0x4F -> no accept during toggling; single digit_valid, digit=3, exactly 3 edges after 0x4F first sampled.
REQ-030 seg_in 0x12 held, then 0x00, then 0x06 -> invalid=1 and err_cnt=1, then invalid=0, then digit=1 with no seq_err.
REQ-031 Force 256 invalid accepts, then err_clr pulsed concurrently with a 257th -> err_cnt holds 255, then reads 0.
REQ-032 rst asserted for 1 cycle mid-stream at digit=5 -> all outputs 0; next glyph 0x6D accepted without seq_err.
